// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - WIDTH/4-stage pipelined carry-lookahead adder/subtractor
module pipelined_cla_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / 4;
    localparam int P = (N > 1) ? N - 1 : 1;

    // Returns {carry_out, carry_into_bit3, sum[3:0]}, every carry flattened from g/p/c0.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] g, p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, c3, p ^ {c3, c2, c1, c0}};
    endfunction

    logic adv;

    // Inter-stage registers: operands travel whole (skew), finished groups accumulate (deskew).
    logic [P-1:0]     pv;
    logic [P-1:0]     pc;
    logic [WIDTH-1:0] pa [P];
    logic [WIDTH-1:0] pb [P];
    logic [WIDTH-1:0] ps [P];

    logic [WIDTH-1:0] ca [N];
    logic [WIDTH-1:0] cb [N];
    logic [WIDTH-1:0] cs_in  [N];
    logic [WIDTH-1:0] cs_out [N];
    logic [N-1:0]     cv, cc_in, cc_out, cc3;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        logic [5:0] r;
        ca[0]    = a;
        cb[0]    = sub ? ~b : b;
        cc_in[0] = sub | cin;
        cs_in[0] = '0;
        cv[0]    = in_valid;
        for (int k = 1; k < N; k++) begin
            ca[k]    = pa[k-1];
            cb[k]    = pb[k-1];
            cc_in[k] = pc[k-1];
            cs_in[k] = ps[k-1];
            cv[k]    = pv[k-1];
        end
        for (int k = 0; k < N; k++) begin
            r                  = cla4(ca[k][4*k +: 4], cb[k][4*k +: 4], cc_in[k]);
            cc_out[k]          = r[5];
            cc3[k]             = r[4];
            cs_out[k]          = cs_in[k];
            cs_out[k][4*k +: 4] = r[3:0];
        end
    end

    // Only valid bits and outputs are reset; data registers just follow the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv        <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < N - 1; k++) begin
                pv[k] <= cv[k];
                pc[k] <= cc_out[k];
                pa[k] <= ca[k];
                pb[k] <= cb[k];
                ps[k] <= cs_out[k];
            end
            out_valid <= cv[N-1];
            sum       <= cs_out[N-1];
            cout      <= cc_out[N-1];
            ovf       <= cc3[N-1] ^ cc_out[N-1];
            zero      <= (cs_out[N-1] == '0);
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - randomized scoreboard bench for pipelined_cla_addsub (WIDTH 16 and 4)
module tb_pipelined_cla_addsub;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v16, rdy16, cin16, sub16, ov16, ordy16, cout16, ovf16, zero16;
    logic [15:0] a16, b16, sum16;
    logic        v4, rdy4, cin4, sub4, ov4, ordy4, cout4, ovf4, zero4;
    logic [3:0]  a4, b4, sum4;

    pipelined_cla_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    pipelined_cla_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4),
        .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(ordy4), .sum(sum4),
        .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    typedef struct packed {
        logic [18:0] exp;
        int          cyc;
    } ent_t;

    ent_t q16[$];
    ent_t q4[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {zero, ovf, cout, sum} from unsigned and signed integer arithmetic.
    function automatic logic [18:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        longint mask, ux, uy, full, sx, sy, sres, half;
        logic [15:0] r;
        logic co, ov;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ux   = longint'(x) & mask;
        uy   = longint'(y) & mask;
        if (s) full = ux + ((~uy) & mask) + 1;
        else   full = ux + uy + longint'(c);
        r    = 16'(full & mask);
        co   = full[w];
        sx   = (ux >= half) ? ux - 2 * half : ux;
        sy   = (uy >= half) ? uy - 2 * half : uy;
        sres = s ? sx - sy : sx + sy + longint'(c);
        ov   = (sres > half - 1) || (sres < -half);
        return {(r == 16'd0), ov, co, r};
    endfunction

    ent_t e;

    // Called right after a negedge with inputs already driven; ends on the next negedge.
    task automatic step();
        #1;
        if (rst_n) begin
            if (ov16 && ordy16) begin
                if (q16.size() == 0) check("w16_unexpected_output", 1, 0);
                else begin
                    e = q16.pop_front();
                    check("w16_result", {zero16, ovf16, cout16, sum16}, e.exp);
                    if (lat_chk) check("w16_latency", cyc - e.cyc, 4);
                end
            end
            if (v16 && rdy16) q16.push_back('{model(16, a16, b16, cin16, sub16), cyc});
            if (ov4 && ordy4) begin
                if (q4.size() == 0) check("w4_unexpected_output", 1, 0);
                else begin
                    e = q4.pop_front();
                    check("w4_result", {zero4, ovf4, cout4, 12'd0, sum4}, e.exp);
                    if (lat_chk) check("w4_latency", cyc - e.cyc, 1);
                end
            end
            if (v4 && rdy4) q4.push_back('{model(4, {12'd0, a4}, {12'd0, b4}, cin4, sub4), cyc});
        end else begin
            q16.delete();
            q4.delete();
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        v16 = 1'b1; a16 = x; b16 = y; cin16 = c; sub16 = s;
        step();
        v16 = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [18:0] snap;
    int          waited;

    initial begin
        rst_n = 1'b0;
        v16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; ordy16 = 1;
        v4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; ordy4 = 1;
        @(negedge clk);
        idle(2);
        check("rst_out_valid16", ov16, 0);
        check("rst_outputs16", {zero16, ovf16, cout16, sum16}, 0);
        check("rst_out_valid4", ov4, 0);
        check("rst_outputs4", {zero4, ovf4, cout4, sum4}, 0);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset16", rdy16, 1);
        check("in_ready_after_reset4", rdy4, 1);

        // Corner cases: carry wrap, signed overflow on add and subtract, borrow.
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send16(16'h8000, 16'h0001, 1'b1, 1'b1);
        send16(16'h0001, 16'h0002, 1'b1, 1'b1);
        send16(16'h1234, 16'h0FFF, 1'b1, 1'b0);
        idle(6);

        // Eight back-to-back random transactions.
        for (int i = 0; i < 8; i++)
            send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        idle(6);

        // Stall with a valid result held for three cycles.
        lat_chk = 1'b0;
        send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        waited = 0;
        while (!ov16 && waited < 10) begin
            step();
            waited++;
        end
        check("stall_result_arrived", ov16, 1);
        snap   = {zero16, ovf16, cout16, sum16};
        ordy16 = 1'b0;
        v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", rdy16, 0);
            check("stall_out_valid", ov16, 1);
            check("stall_outputs_stable", {zero16, ovf16, cout16, sum16}, snap);
            step();
        end
        ordy16 = 1'b1;
        v16    = 1'b0;
        idle(6);

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            v16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
            cin16 = 1'($urandom); sub16 = 1'($urandom);
            ordy16 = ($urandom_range(0, 3) != 0);
            step();
        end
        v16 = 1'b0; ordy16 = 1'b1;
        idle(8);
        lat_chk = 1'b1;

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++)
            send16(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("flush_out_valid", ov16, 0);
        idle(6);
        send16(16'h0003, 16'h0004, 1'b0, 1'b0);
        waited = 0;
        while (!ov16 && waited < 10) begin
            step();
            waited++;
        end
        check("fresh_after_flush_sum", sum16, 16'h0007);
        idle(2);

        // WIDTH=4: every a/b/cin combination in add mode, then every a/b in subtract mode.
        for (int i = 0; i < 512; i++) begin
            v4 = 1'b1; a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); sub4 = 1'b0;
            step();
        end
        for (int i = 0; i < 256; i++) begin
            v4 = 1'b1; a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'($urandom); sub4 = 1'b1;
            step();
        end
        v4 = 1'b0;

        waited = 0;
        while ((q16.size() != 0 || q4.size() != 0) && waited < 50) begin
            step();
            waited++;
        end
        check("drain_w16", q16.size(), 0);
        check("drain_w4", q4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 4 from 4 to 64.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 Port rst_n: input, 1 bit, synchronous active-low reset.
REQ-005 Port in_valid: input, 1 bit, operand set presented.
REQ-006 Port in_ready: output, 1 bit, block accepts an operand set this cycle.
REQ-007 Port a: input, WIDTH bits, operand A.
REQ-008 Port b: input, WIDTH bits, operand B.
REQ-009 Port cin: input, 1 bit, carry-in; used only when sub=0.
REQ-010 Port sub: input, 1 bit, 0 = add, 1 = subtract.
REQ-011 Port out_valid: output, 1 bit, result presented.
REQ-012 Port out_ready: input, 1 bit, downstream accepts the result.
REQ-013 Port sum: output, WIDTH bits, result.
REQ-014 Port cout: output, 1 bit, carry out of the MSB.
REQ-015 Port ovf: output, 1 bit, signed two's-complement overflow.
REQ-016 Port zero: output, 1 bit, sum == 0.

Function
REQ-017 Add mode SHALL compute {cout,sum} = a + b + cin.
REQ-018 Subtract mode SHALL compute {cout,sum} = a + ~b + 1 and ignore cin; cout=1 means no borrow.
REQ-019 Arithmetic SHALL be split into N = WIDTH/4 groups, with stage k holding bits [4k+3:4k].
REQ-020 Each group SHALL use 4-bit carry lookahead: per-bit g=a&b and p=a^b, with all internal carries formed from g, p and the group carry-in, and no intra-group ripple.
REQ-021 The group carry-out SHALL be registered into stage k+1.
REQ-022 Unprocessed upper operand bits SHALL be delayed by a skew register, and finished lower sum bits by a deskew register, so that all WIDTH result bits of one transaction emerge together.
REQ-023 ovf SHALL equal the carry into the MSB XOR cout.
REQ-024 zero SHALL be computed on the final sum, and all flags SHALL be registered with sum.
REQ-025 Latency SHALL be exactly N cycles from the accepting edge (in_valid & in_ready) to out_valid=1, with no bubble.
REQ-026 Pipeline advance SHALL be adv = !out_valid | out_ready, and in_ready SHALL equal adv (combinational).
REQ-027 When adv=0, all stage registers SHALL hold, and sum, cout, ovf and zero SHALL remain stable while out_valid=1.
REQ-028 When adv=1, every stage SHALL shift, and a per-stage valid bit SHALL propagate (in_valid & in_ready enters stage 0).
REQ-029 Throughput SHALL be one transaction per cycle while out_ready=1, and results SHALL be returned strictly in acceptance order.
REQ-030 A simultaneous accept and emit in one cycle SHALL be legal and lose no data.
REQ-031 When in_valid=0 and adv=1, the pipeline SHALL insert a bubble (valid bit 0); data registers are don't-care.
REQ-032 The block SHALL hold no state machine beyond the valid shift chain, and the pipeline SHALL never overflow by construction.

Reset
REQ-033 While rst_n=0 at a clock edge, all valid bits SHALL clear to 0, and sum, cout, ovf and zero SHALL clear to 0.
REQ-034 Only the valid bits and outputs need reset; internal data registers need not be reset.
REQ-035 A reset mid-operation SHALL discard all in-flight transactions, which never appear at the output.
REQ-036 in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-037 WIDTH=16, add 0xFFFF+0x0001, cin=0 -> after 4 cycles: sum=0x0000, cout=1, zero=1, ovf=0.
REQ-038 WIDTH=16, add 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
REQ-039 WIDTH=16, sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1; then sub 0x0001-0x0002 -> sum=0xFFFF, cout=0, ovf=0.
REQ-040 WIDTH=16, 8 back-to-back random transactions with out_ready=1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept, in order, matching the model.
REQ-041 Hold out_ready=0 for 3 cycles while a result is valid -> outputs are bit-stable, in_ready=0, and no transaction is lost or duplicated after release.
REQ-042 Reset with 3 transactions in flight -> out_valid=0 next cycle, none emerge, and a fresh 0x0003+0x0004 returns 0x0007; for WIDTH=4 (N=1), all 512 a/b/cin combos match the model with 1-cycle latency.
